execute: RTL and testbench

//  - Execute stage of the 5-stage RV32I pipeline; consumes the decode->execute register outputs.
//  - Selects ALU operands, computes the ALU result, resolves branches/jumps and drives the PC redirect to fetch.
//  - Registers the results into the execute->memory pipeline register, which supports stall (hold) and flush (bubble).

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/alu.sv | 36 +++
 rtl/execute.sv | 101 ++++++++++
 tb/tb_execute.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the RV32I pipeline.
// Covers the ALU operation, the operand-select encodings and the branch func3 codes.
package cpu_pkg;

    localparam int WORD      = 32;
    localparam int REG_SIZE  = 5;
    localparam int REG_COUNT = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_ctl_t;

    typedef enum logic [1:0] {
        ALU_SRC_RD2       = 2'd0,
        ALU_SRC_IMM       = 2'd1,
        ALU_SRC_PC_PLUS_4 = 2'd2
    } alu_src_t;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU.
// An unknown operation code yields zero rather than x.
import cpu_pkg::*;

module alu (
    input  logic [WORD-1:0] a,
    input  logic [WORD-1:0] b,
    input  logic [3:0]      ctl,
    output logic [WORD-1:0] result,
    output logic            zero
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_ctl_t'(ctl))
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: result = {31'd0, a < b};
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << shamt;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = $signed(a) >>> shamt;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/execute.sv
// Execute stage: ALU, branch/jump resolution, and the E->M register.
// The E->M register supports hold (stallM) and bubble (flushM).
import cpu_pkg::*;

module execute (
    input  logic                clk,
    input  logic                reset,
    input  logic [WORD-1:0]     rdata1E,
    input  logic [WORD-1:0]     rdata2E,
    input  logic [WORD-1:0]     immE,
    input  logic [WORD-1:0]     pcE,
    input  logic [REG_SIZE-1:0] writeRegE,
    input  logic [3:0]          ALUControlE,
    input  logic [1:0]          ALUSrcE,
    input  logic                regWriteE,
    input  logic                memWriteE,
    input  logic                mem2regE,
    input  logic                branchE,
    input  logic                jumpE,
    input  logic                jalrE,
    input  logic [2:0]          func3E,
    input  logic                stallM,
    input  logic                flushM,
    output logic                pcSrcE,
    output logic [WORD-1:0]     pcTargetE,
    output logic [WORD-1:0]     aluOutM,
    output logic [WORD-1:0]     writeDataM,
    output logic [REG_SIZE-1:0] writeRegM,
    output logic                regWriteM,
    output logic                memWriteM,
    output logic                mem2regM
);

    logic [WORD-1:0] op_a;
    logic [WORD-1:0] op_b;
    logic [WORD-1:0] result;
    logic            zero;
    logic            cond;
    logic [WORD-1:0] target_sum;

    always_comb begin
        op_a = rdata1E;
        op_b = rdata2E;
        case (alu_src_t'(ALUSrcE))
            ALU_SRC_PC_PLUS_4: begin
                op_a = pcE;
                op_b = 32'd4;
            end
            ALU_SRC_IMM: op_b = immE;
            default:     op_b = rdata2E;
        endcase
    end

    alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .ctl    (ALUControlE),
        .result (result),
        .zero   (zero)
    );

    // Decode picks SUB for eq/ne and SLT/SLTU for the ordered compares.
    always_comb begin
        cond = 1'b0;
        case (func3E)
            BR_BEQ:  cond = zero;
            BR_BNE:  cond = ~zero;
            BR_BLT:  cond = result[0];
            BR_BLTU: cond = result[0];
            BR_BGE:  cond = ~result[0];
            BR_BGEU: cond = ~result[0];
            default: cond = 1'b0;
        endcase
    end

    // Suppressed while stalled so a held branch redirects only once.
    assign pcSrcE = (jumpE | (branchE & cond)) & ~stallM;

    assign target_sum = (jalrE ? rdata1E : pcE) + immE;
    assign pcTargetE  = jalrE ? {target_sum[WORD-1:1], 1'b0}
                              : target_sum;

    always_ff @(posedge clk) begin
        if (reset || flushM) begin
            aluOutM    <= '0;
            writeDataM <= '0;
            writeRegM  <= '0;
            regWriteM  <= 1'b0;
            memWriteM  <= 1'b0;
            mem2regM   <= 1'b0;
        end else if (!stallM) begin
            aluOutM    <= result;
            writeDataM <= rdata2E;
            writeRegM  <= writeRegE;
            regWriteM  <= regWriteE;
            memWriteM  <= memWriteE;
            mem2regM   <= mem2regE;
        end
    end

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for the execute stage.
// Directed cases followed by randomized cycles against a behavioural model.
module tb_execute;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] rdata1E, rdata2E, immE, pcE;
    logic [4:0]  writeRegE;
    logic [3:0]  ALUControlE;
    logic [1:0]  ALUSrcE;
    logic        regWriteE, memWriteE, mem2regE, branchE;
    logic        jumpE, jalrE;
    logic [2:0]  func3E;
    logic        stallM, flushM;
    logic        pcSrcE;
    logic [31:0] pcTargetE, aluOutM, writeDataM;
    logic [4:0]  writeRegM;
    logic        regWriteM, memWriteM, mem2regM;

    int compared = 0;
    int mismatched = 0;

    // Expected E->M contents
    logic [31:0] e_alu, e_wd;
    logic [4:0]  e_wr;
    logic        e_rw, e_mw, e_m2r;

    always #5 clk = ~clk;

    execute dut (
        .clk(clk), .reset(reset),
        .rdata1E(rdata1E), .rdata2E(rdata2E),
        .immE(immE), .pcE(pcE), .writeRegE(writeRegE),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
        .regWriteE(regWriteE), .memWriteE(memWriteE),
        .mem2regE(mem2regE), .branchE(branchE),
        .jumpE(jumpE), .jalrE(jalrE), .func3E(func3E),
        .stallM(stallM), .flushM(flushM),
        .pcSrcE(pcSrcE), .pcTargetE(pcTargetE),
        .aluOutM(aluOutM), .writeDataM(writeDataM),
        .writeRegM(writeRegM), .regWriteM(regWriteM),
        .memWriteM(memWriteM), .mem2regM(mem2regM)
    );

    function automatic logic [31:0] m_a();
        return (ALUSrcE == 2'd2) ? pcE : rdata1E;
    endfunction

    function automatic logic [31:0] m_b();
        if (ALUSrcE == 2'd2) return 32'd4;
        if (ALUSrcE == 2'd1) return immE;
        return rdata2E;
    endfunction

    function automatic logic [31:0] m_alu(
        input logic [3:0] op,
        input logic [31:0] a,
        input logic [31:0] b
    );
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return (sa < sb) ? 32'd1 : 32'd0;
            4'd3: return (a < b) ? 32'd1 : 32'd0;
            4'd4: return a & b;
            4'd5: return a | b;
            4'd6: return a ^ b;
            4'd7: return a << (b % 32);
            4'd8: return a >> (b % 32);
            4'd9: return 32'(sa >>> (b % 32));
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_pcsrc();
        logic [31:0] r;
        logic        c;
        r = m_alu(ALUControlE, m_a(), m_b());
        case (func3E)
            3'b000: c = (r == 0);
            3'b001: c = (r != 0);
            3'b100, 3'b110: c = r[0];
            3'b101, 3'b111: c = !r[0];
            default: c = 1'b0;
        endcase
        if (stallM) return 1'b0;
        return jumpE || (branchE && c);
    endfunction

    function automatic logic [31:0] m_target();
        logic [31:0] t;
        t = (jalrE ? rdata1E : pcE) + immE;
        if (jalrE) t = t & ~32'd1;
        return t;
    endfunction

    task automatic chk(
        input string tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (reset || flushM) begin
            e_alu = 0; e_wd = 0; e_wr = 0;
            e_rw = 0; e_mw = 0; e_m2r = 0;
        end else if (!stallM) begin
            e_alu = m_alu(ALUControlE, m_a(), m_b());
            e_wd = rdata2E; e_wr = writeRegE;
            e_rw = regWriteE; e_mw = memWriteE;
            e_m2r = mem2regE;
        end
    endtask

    // Inputs are already set; check E outputs, clock, check M outputs.
    task automatic cycle(input string tag);
        #1;
        chk({tag, "_pcsrc"}, {31'd0, pcSrcE}, {31'd0, m_pcsrc()});
        chk({tag, "_tgt"}, pcTargetE, m_target());
        model_edge();
        @(posedge clk);
        #1;
        chk({tag, "_alu"}, aluOutM, e_alu);
        chk({tag, "_wd"}, writeDataM, e_wd);
        chk({tag, "_wr"}, {27'd0, writeRegM}, {27'd0, e_wr});
        chk({tag, "_ctl"},
            {29'd0, regWriteM, memWriteM, mem2regM},
            {29'd0, e_rw, e_mw, e_m2r});
    endtask

    task automatic clear_in();
        rdata1E = 0; rdata2E = 0; immE = 0; pcE = 0;
        writeRegE = 0; ALUControlE = 0; ALUSrcE = 0;
        regWriteE = 0; memWriteE = 0; mem2regE = 0;
        branchE = 0; jumpE = 0; jalrE = 0; func3E = 0;
        stallM = 0; flushM = 0;
    endtask

    initial begin
        e_alu = 0; e_wd = 0; e_wr = 0;
        e_rw = 0; e_mw = 0; e_m2r = 0;
        clear_in();
        reset = 1;
        @(posedge clk);
        #1;
        cycle("reset");
        chk("reset_alu0", aluOutM, 32'd0);
        reset = 0;

        // 1: ADD immediate
        rdata1E = 5; immE = -32'sd3; ALUSrcE = 2'd1;
        ALUControlE = 4'd0; regWriteE = 1; writeRegE = 5'd3;
        cycle("t1");
        chk("t1_two", aluOutM, 32'd2);
        chk("t1_rw", {31'd0, regWriteM}, 32'd1);

        // 2: beq taken, then not taken
        clear_in();
        branchE = 1; func3E = 3'b000; ALUControlE = 4'd1;
        rdata1E = 7; rdata2E = 7; pcE = 32'h100; immE = 32'h20;
        #1;
        chk("t2_taken", {31'd0, pcSrcE}, 32'd1);
        chk("t2_tgt", pcTargetE, 32'h120);
        cycle("t2a");
        rdata2E = 8;
        #1;
        chk("t2_nt", {31'd0, pcSrcE}, 32'd0);
        cycle("t2b");

        // 3: blt vs bltu with -1 and 1
        rdata1E = 32'hFFFF_FFFF; rdata2E = 1;
        func3E = 3'b100; ALUControlE = 4'd2;
        #1;
        chk("t3_blt", {31'd0, pcSrcE}, 32'd1);
        cycle("t3a");
        func3E = 3'b110; ALUControlE = 4'd3;
        #1;
        chk("t3_bltu", {31'd0, pcSrcE}, 32'd0);
        cycle("t3b");

        // 4: JALR link value and target
        clear_in();
        jumpE = 1; jalrE = 1; pcE = 32'h40; rdata1E = 32'h203;
        immE = 0; ALUSrcE = 2'd2; ALUControlE = 4'd0;
        regWriteE = 1; writeRegE = 5'd1;
        #1;
        chk("t4_tgt", pcTargetE, 32'h202);
        chk("t4_src", {31'd0, pcSrcE}, 32'd1);
        cycle("t4");
        chk("t4_link", aluOutM, 32'h44);

        // 5: stall twice with changing inputs, then flush+stall
        stallM = 1;
        for (int i = 0; i < 2; i++) begin
            rdata1E = $urandom; pcE = $urandom;
            memWriteE = 1; writeRegE = 5'(i + 7);
            cycle("t5_stall");
            chk("t5_hold", aluOutM, 32'h44);
        end
        flushM = 1; regWriteE = 1;
        cycle("t5_flush");
        chk("t5_ctl", {30'd0, regWriteM, memWriteM}, 32'd0);

        // 6: reset during a store, then SRA
        clear_in();
        memWriteE = 1; rdata2E = 32'hDEAD_BEEF; rdata1E = 32'h1000;
        immE = 8; ALUSrcE = 2'd1; reset = 1;
        cycle("t6_rst");
        chk("t6_mw", {31'd0, memWriteM}, 32'd0);
        reset = 0;
        clear_in();
        rdata1E = 32'h8000_0000; immE = 4; ALUSrcE = 2'd1;
        ALUControlE = 4'd9; regWriteE = 1;
        cycle("t6_sra");
        chk("t6_sra_val", aluOutM, 32'hF800_0000);

        // Randomized traffic, including undefined ALU codes
        for (int i = 0; i < 300; i++) begin
            rdata1E = $urandom; rdata2E = $urandom;
            immE = $urandom; pcE = $urandom;
            if ($urandom_range(0, 3) == 0) rdata2E = rdata1E;
            writeRegE = 5'($urandom);
            ALUControlE = 4'($urandom);
            ALUSrcE = 2'($urandom_range(0, 2));
            regWriteE = 1'($urandom); memWriteE = 1'($urandom);
            mem2regE = 1'($urandom); branchE = 1'($urandom);
            jumpE = ($urandom_range(0, 5) == 0);
            jalrE = 1'($urandom);
            func3E = 3'($urandom);
            stallM = ($urandom_range(0, 4) == 0);
            flushM = ($urandom_range(0, 6) == 0);
            reset = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end
        reset = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
